// File: rtl/spram32_port.sv
// rtl/spram32_port.sv - byte-addressed load/store initiator for the 32Kx32 SPRAM
// Splits misaligned accesses into two word beats and realigns/zero-extends load data.
module spram32_port #(
  parameter int ASZ = 15,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  output logic           rdy,
  input  logic           we,
  input  logic [1:0]     sz,
  input  logic [ASZ+1:0] ba,
  input  logic [DSZ-1:0] wd,
  output logic [DSZ-1:0] rd,
  output logic           rvld,
  output logic           m_we,
  output logic [3:0]     m_bmsk,
  output logic [ASZ-1:0] m_a,
  output logic [DSZ-1:0] m_vi,
  input  logic [DSZ-1:0] m_vo
);

  typedef enum logic {S_IDLE, S_BEAT2} state_t;

  function automatic logic [3:0] size_lanes(input logic [1:0] s);
    logic [3:0] l;
    case (s)
      2'b00:   l = 4'b0001;
      2'b01:   l = 4'b0011;
      default: l = 4'b1111;
    endcase
    return l;
  endfunction

  function automatic logic [31:0] lanes_to_bits(input logic [3:0] l);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{l[i]}};
    return m;
  endfunction

  state_t         r_state;
  state_t         w_next;

  logic [1:0]     w_off;
  logic [ASZ-1:0] w_word;
  logic [3:0]     w_lanes;
  logic [7:0]     w_msk8;
  logic           w_split;
  logic           w_accept;
  logic [63:0]    w_vi64;

  // Beat-2 parameters captured at acceptance of a split request
  logic [ASZ-1:0] r_b2_a;
  logic [3:0]     r_b2_msk;
  logic [31:0]    r_b2_vi;
  logic           r_b2_we;
  logic [1:0]     r_b2_off;
  logic [1:0]     r_b2_sz;

  // p1 describes the beat currently on m_*, p2 the beat whose data is on m_vo
  logic           r_p1_vld, r_p1_last, r_p1_split;
  logic [1:0]     r_p1_off, r_p1_sz;
  logic           r_p2_vld, r_p2_last, r_p2_split;
  logic [1:0]     r_p2_off, r_p2_sz;
  logic [31:0]    r_hold;

  logic [31:0]    w_lo;
  logic [23:0]    w_hi;
  logic [31:0]    w_algn;
  logic [31:0]    w_rd;

  assign w_off    = ba[1:0];
  assign w_word   = ba[ASZ+1:2];
  assign w_lanes  = size_lanes(sz);
  assign w_msk8   = {4'b0000, w_lanes} << w_off;
  assign w_split  = |w_msk8[7:4];
  assign w_accept = req & rdy;
  assign w_vi64   = {32'h0, wd & lanes_to_bits(w_lanes)} << {w_off, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_split) w_next = S_BEAT2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rdy = (r_state == S_IDLE);
  end

  // Top byte of beat-2 data is never needed: at most 7 bytes span two words
  always_comb begin
    w_lo = r_p2_split ? r_hold : m_vo;
    w_hi = r_p2_split ? m_vo[23:0] : 24'h0;
    case (r_p2_off)
      2'd0:    w_algn = w_lo;
      2'd1:    w_algn = {w_hi[7:0],  w_lo[31:8]};
      2'd2:    w_algn = {w_hi[15:0], w_lo[31:16]};
      default: w_algn = {w_hi[23:0], w_lo[31:24]};
    endcase
    w_rd = w_algn & lanes_to_bits(size_lanes(r_p2_sz));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_we       <= 1'b0;
      m_bmsk     <= 4'b0000;
      m_a        <= '0;
      m_vi       <= '0;
      r_b2_a     <= '0;
      r_b2_msk   <= 4'b0000;
      r_b2_vi    <= '0;
      r_b2_we    <= 1'b0;
      r_b2_off   <= 2'b00;
      r_b2_sz    <= 2'b00;
      r_p1_vld   <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_split <= 1'b0;
      r_p1_off   <= 2'b00;
      r_p1_sz    <= 2'b00;
      r_p2_vld   <= 1'b0;
      r_p2_last  <= 1'b0;
      r_p2_split <= 1'b0;
      r_p2_off   <= 2'b00;
      r_p2_sz    <= 2'b00;
      r_hold     <= '0;
      rd         <= '0;
      rvld       <= 1'b0;
    end else begin
      m_we       <= 1'b0;
      m_bmsk     <= 4'b0000;
      r_p1_vld   <= 1'b0;
      r_p2_vld   <= r_p1_vld;
      r_p2_last  <= r_p1_last;
      r_p2_split <= r_p1_split;
      r_p2_off   <= r_p1_off;
      r_p2_sz    <= r_p1_sz;
      rvld       <= 1'b0;

      if (r_state == S_BEAT2) begin
        m_a        <= r_b2_a;
        m_we       <= r_b2_we;
        m_bmsk     <= r_b2_we ? r_b2_msk : 4'b1111;
        if (r_b2_we) m_vi <= r_b2_vi;
        r_p1_vld   <= ~r_b2_we;
        r_p1_last  <= 1'b1;
        r_p1_split <= 1'b1;
        r_p1_off   <= r_b2_off;
        r_p1_sz    <= r_b2_sz;
      end else if (w_accept) begin
        m_a        <= w_word;
        m_we       <= we;
        m_bmsk     <= we ? w_msk8[3:0] : 4'b1111;
        if (we) m_vi <= w_vi64[31:0];
        r_p1_vld   <= ~we;
        r_p1_last  <= ~w_split;
        r_p1_split <= w_split;
        r_p1_off   <= w_off;
        r_p1_sz    <= sz;
        r_b2_a     <= w_word + ASZ'(1);
        r_b2_msk   <= w_msk8[7:4];
        r_b2_vi    <= w_vi64[63:32];
        r_b2_we    <= we;
        r_b2_off   <= w_off;
        r_b2_sz    <= sz;
      end

      if (r_p2_vld) begin
        if (r_p2_last) begin
          rd   <= w_rd;
          rvld <= 1'b1;
        end else begin
          r_hold <= m_vo;
        end
      end
    end
  end

endmodule

// File: tb/tb_spram32_port.sv
// tb/tb_spram32_port.sv - self-checking bench for spram32_port
// Byte-level memory model predicts load data and rvld cycles; an SPRAM model backs the DUT.
module tb_spram32_port;

  logic        clk = 1'b0;
  logic        rst_n, req, we;
  logic [1:0]  sz;
  logic [16:0] ba;
  logic [31:0] wd, rd, m_vi;
  logic [31:0] m_vo = 32'h0;
  logic        rdy, rvld, m_we;
  logic [3:0]  m_bmsk;
  logic [14:0] m_a;

  int cyc = 0, n_cmp = 0, n_fail = 0, bus_cnt = 0;
  logic [31:0] got_d[$], exp_d[$];
  int          got_c[$], exp_c[$];
  bit [31:0]   sram [0:32767];
  bit [7:0]    bmem [0:131071];

  spram32_port #(.ASZ(15), .DSZ(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .we(we), .sz(sz), .ba(ba),
    .wd(wd), .rd(rd), .rvld(rvld), .m_we(m_we), .m_bmsk(m_bmsk), .m_a(m_a),
    .m_vi(m_vi), .m_vo(m_vo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_we) begin
      for (int l = 0; l < 4; l++)
        if (m_bmsk[l]) sram[m_a][8*l +: 8] <= m_vi[8*l +: 8];
    end else begin
      m_vo <= sram[m_a];
    end
  end

  always @(negedge clk) begin
    if (rvld) begin
      got_d.push_back(rd);
      got_c.push_back(cyc);
    end
    if (m_we || m_bmsk != 4'b0000) bus_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic void model_access(input logic w, input logic [1:0] s, input logic [16:0] a,
                                       input logic [31:0] d, input int acc);
    int n;
    logic [31:0] v;
    logic [16:0] ai;
    n = size_bytes(s);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = a + 17'(i);
      if (w) bmem[ai] = d[8*i +: 8];
      else   v[8*i +: 8] = bmem[ai];
    end
    if (!w) begin
      exp_d.push_back(v);
      exp_c.push_back(acc + (((int'(a[1:0]) + n) > 4) ? 3 : 2));
    end
  endfunction

  function automatic logic [31:0] first_d();
    return (got_d.size() > 0) ? got_d[0] : 32'hxxxxxxxx;
  endfunction

  function automatic int first_c();
    return (got_c.size() > 0) ? got_c[0] : -1;
  endfunction

  task automatic flush();
    got_d.delete(); got_c.delete(); exp_d.delete(); exp_c.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic issue(input logic w, input logic [1:0] s, input logic [16:0] a,
                       input logic [31:0] d, output int acc);
    int b;
    req = 1'b1; we = w; sz = s; ba = a; wd = d;
    b = 0;
    while (!rdy && b < 10) begin
      @(posedge clk); #1;
      b++;
    end
    n_cmp++;
    if (!rdy) begin
      n_fail++;
      $display("FAIL issue_timeout rdy=%b want 1 within 10 cycles", rdy);
    end
    @(posedge clk); #1;
    acc = cyc;
    model_access(w, s, a, d, acc);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", rdy); end
    n_cmp++; if (rvld !== 1'b0) begin n_fail++; $display("FAIL reset_rvld got %b want 0", rvld); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd); end
    n_cmp++;
    if (m_we !== 1'b0 || m_bmsk !== 4'b0000 || m_a !== 15'h0 || m_vi !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus got we=%b bmsk=%b a=%h vi=%h want 0 0000 0000 00000000", m_we, m_bmsk, m_a, m_vi);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int acc;
    issue(1'b1, 2'b10, 17'h00004, 32'hDEADBEEF, acc);
    n_cmp++;
    if (m_a !== 15'h0001 || m_bmsk !== 4'b1111 || m_we !== 1'b1 || m_vi !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_store got a=%h bmsk=%b we=%b vi=%h want 0001 1111 1 deadbeef", m_a, m_bmsk, m_we, m_vi);
    end
    issue(1'b0, 2'b10, 17'h00004, 32'h0, acc);
    req = 1'b0;
    n_cmp++;
    if (m_a !== 15'h0001 || m_bmsk !== 4'b1111 || m_we !== 1'b0) begin
      n_fail++;
      $display("FAIL word_load_bus got a=%h bmsk=%b we=%b want 0001 1111 0", m_a, m_bmsk, m_we);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 1 || first_d() !== 32'hDEADBEEF || first_c() != acc + 2) begin
      n_fail++;
      $display("FAIL word_load got n=%0d rd=%h cyc=%0d want 1 deadbeef %0d", got_d.size(), first_d(), first_c(), acc + 2);
    end
    flush();
  endtask

  task automatic test_byte();
    int acc;
    issue(1'b1, 2'b00, 17'h00006, 32'h000001A5, acc);
    n_cmp++;
    if (m_bmsk !== 4'b0100 || m_vi !== 32'h00A50000 || m_a !== 15'h0001) begin
      n_fail++;
      $display("FAIL byte_store got bmsk=%b vi=%h a=%h want 0100 00a50000 0001", m_bmsk, m_vi, m_a);
    end
    issue(1'b0, 2'b00, 17'h00006, 32'h0, acc);
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 1 || first_d() !== 32'h000000A5 || first_c() != acc + 2) begin
      n_fail++;
      $display("FAIL byte_load got n=%0d rd=%h cyc=%0d want 1 000000a5 %0d", got_d.size(), first_d(), first_c(), acc + 2);
    end
    flush();
  endtask

  task automatic test_split();
    int acc;
    issue(1'b1, 2'b10, 17'h00003, 32'h11223344, acc);
    req = 1'b0;
    n_cmp++;
    if (m_a !== 15'h0000 || m_bmsk !== 4'b1000 || m_vi !== 32'h44000000 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL split_beat1 got a=%h bmsk=%b vi=%h rdy=%b want 0000 1000 44000000 0", m_a, m_bmsk, m_vi, rdy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_a !== 15'h0001 || m_bmsk !== 4'b0111 || m_vi !== 32'h00112233 || m_we !== 1'b1 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL split_beat2 got a=%h bmsk=%b vi=%h we=%b rdy=%b want 0001 0111 00112233 1 1", m_a, m_bmsk, m_vi, m_we, rdy);
    end
    issue(1'b0, 2'b10, 17'h00003, 32'h0, acc);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 1 || first_d() !== 32'h11223344 || first_c() != acc + 3) begin
      n_fail++;
      $display("FAIL split_load got n=%0d rd=%h cyc=%0d want 1 11223344 %0d", got_d.size(), first_d(), first_c(), acc + 3);
    end
    flush();
  endtask

  task automatic test_wrap();
    int acc;
    issue(1'b1, 2'b01, 17'h1FFFF, 32'h0000BEEF, acc);
    req = 1'b0;
    n_cmp++;
    if (m_a !== 15'h7FFF || m_bmsk !== 4'b1000 || m_vi !== 32'hEF000000) begin
      n_fail++;
      $display("FAIL wrap_beat1 got a=%h bmsk=%b vi=%h want 7fff 1000 ef000000", m_a, m_bmsk, m_vi);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (m_a !== 15'h0000 || m_bmsk !== 4'b0001 || m_vi !== 32'h000000BE) begin
      n_fail++;
      $display("FAIL wrap_beat2 got a=%h bmsk=%b vi=%h want 0000 0001 000000be", m_a, m_bmsk, m_vi);
    end
    issue(1'b0, 2'b01, 17'h1FFFF, 32'h0, acc);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 1 || first_d() !== 32'h0000BEEF || first_c() != acc + 3) begin
      n_fail++;
      $display("FAIL wrap_load got n=%0d rd=%h cyc=%0d want 1 0000beef %0d", got_d.size(), first_d(), first_c(), acc + 3);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    int acc[4];
    for (int i = 0; i < 4; i++) issue(1'b1, 2'b10, 17'(4 * i), $urandom, acc[i]);
    for (int i = 0; i < 4; i++) issue(1'b0, 2'b10, 17'(4 * i), 32'h0, acc[i]);
    req = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (acc[i] != acc[i-1] + 1) begin
        n_fail++;
        $display("FAIL b2b_accept[%0d] got cyc=%0d want %0d", i, acc[i], acc[i-1] + 1);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 4", got_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL b2b_load[%0d] got rd=%h cyc=%0d want %h %0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
    flush();
  endtask

  task automatic test_random();
    int acc, n, nexp;
    logic w;
    logic [1:0] s;
    logic [16:0] a;
    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 17'h1FFF8 + 17'($urandom_range(0, 7))
                                       : 17'($urandom_range(0, 63));
      issue(w, s, a, $urandom, acc);
      n = size_bytes(s);
      n_cmp++;
      if (rdy !== (((int'(a[1:0]) + n) > 4) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL rand_rdy[%0d] got %b ba=%h sz=%b", k, rdy, a, s);
      end
      if ($urandom_range(0, 3) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    nexp = exp_d.size();
    n_cmp++;
    if (got_d.size() != nexp) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", got_d.size(), nexp);
    end
    for (int i = 0; i < nexp && i < got_d.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i]) begin
        n_fail++;
        $display("FAIL rand_load[%0d] got rd=%h cyc=%0d want %h %0d", i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
    flush();
  endtask

  task automatic test_reset_beat2();
    int acc, bus_before;
    issue(1'b0, 2'b10, 17'h00011, 32'h0, acc);
    req = 1'b0;
    n_cmp++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL rst_b2_pre rdy got %b want 0", rdy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_we !== 1'b0 || m_bmsk !== 4'b0000 || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_b2_async got we=%b bmsk=%b rdy=%b want 0 0000 1", m_we, m_bmsk, rdy);
    end
    bus_before = bus_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (got_d.size() != 0 || bus_cnt != bus_before || rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_b2_after got rvlds=%0d bus_beats=%0d rdy=%b want 0 0 1", got_d.size(), bus_cnt - bus_before, rdy);
    end
    flush();
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; sz = 2'b00; ba = '0; wd = '0;
    test_reset();
    test_word();
    test_byte();
    test_split();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_beat2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spram32_port.md
# spram32_port

Byte-addressed initiator for the 32K×32 single-port SPRAM (`spram32_32k`). It accepts byte, halfword and word load/store requests from the Forth core's data path and converts each one into SPRAM word cycles with byte-lane masks. Misaligned accesses are split into two beats, and read data is realigned and zero-extended. It sits between the eForth core's memory stage and the SPRAM macro.

## Interface
- `ASZ`, 15, SPRAM word-address width (32K words; byte address is ASZ+2 bits)
- `DSZ`, 32, data width (fixed at 32; other values unsupported)
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  1  request valid
- `rdy`  out  1  request accepted at a rising edge when `req & rdy`
- `we`  in  1  1 = store, 0 = load
- `sz`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `ba`  in  ASZ+2  byte address, little-endian
- `wd`  in  DSZ  store data, right-justified; bits above `sz` ignored
- `rd`  out  DSZ  load data, right-justified, zero-extended
- `rvld`  out  1  `rd` valid, one-cycle pulse per load
- `m_we`  out  1  SPRAM write enable
- `m_bmsk`  out  4  SPRAM byte-lane mask, bit n = lane n = bits 8n+7:8n
- `m_a`  out  ASZ  SPRAM word address
- `m_vi`  out  DSZ  SPRAM write data
- `m_vo`  in  DSZ  SPRAM read data; valid the cycle after the edge that samples `m_a` with `m_we=0`

## Operation
- Offset `off = ba[1:0]`, word `w = ba[ASZ+1:2]`. Size in bytes `n` is 1, 2 or 4.
- Split when `off + n > 4`. A byte access never splits. A halfword splits only at off=3. A word splits at any off≠0.
- Lane mask, 8 bits: `((1<<n)-1) << off`. Beat 1 uses bits 3:0 at word w. Beat 2 uses bits 7:4 at word `(w+1) mod 2^ASZ`; this wraps at the top of memory.
- Store data: the 64-bit value `wd << 8*off`. Beat 1 `m_vi` is bits 31:0; beat 2 `m_vi` is bits 63:32.
- Load: `{beat2 m_vo, beat1 m_vo} >> 8*off`, masked to n bytes and zero-extended. For a non-split load, beat 2 is taken as 0.
- Loads drive `m_bmsk=1111` and `m_we=0`.
- FSM:
  - IDLE: `rdy=1`. An accepted non-split request stays in IDLE. An accepted split request goes to BEAT2.
  - BEAT2: `rdy=0`. Issues beat 2, then returns to IDLE unconditionally.
- A load pipeline of 2 stages tracks in-flight beats. Beat-1 data of a split load is held in a register until beat-2 data arrives.
- Idle cycles drive `m_we=0` and `m_bmsk=0000`; `m_a` holds its last value.

## Timing
- All `m_*` outputs, `rd` and `rvld` are registered.
- Reset values: state IDLE, `rdy=1`, `rvld=0`, `rd=0`, `m_we=0`, `m_bmsk=0`, `m_a=0`, `m_vi=0`. Pipeline and hold registers clear to 0.
- Acceptance edge E0: beat-1 `m_*` values are registered, and the SPRAM executes beat 1 at E1.
- Non-split request: `rdy` stays 1, and the next request can be accepted at E1. This gives full throughput, one access per cycle.
- Split request: `rdy=0` in cycle E0–E1. Beat-2 `m_*` values are registered at E1 and the SPRAM executes beat 2 at E2. The next request can be accepted at E2.
- Load latency: non-split, `rvld=1` in cycle E2–E3; split, `rvld=1` in cycle E3–E4. `rvld` pulses are returned in request order.
- Back-to-back loads and stores interleave freely. A store never disturbs `rd` of an earlier load.
- Reset mid-operation: a pending beat 2 is dropped and in-flight loads are discarded (no `rvld`). `m_we` goes to 0 asynchronously.

## Test plan
- Aligned word store `ba=0x00004`, `wd=DEADBEEF` -> `m_a=1`, `m_bmsk=1111`, `m_we=1`. A following load of 0x00004 gives `rd=DEADBEEF` with `rvld` at E2.
- Byte store `ba=0x00006`, `wd=0x1A5` -> `m_bmsk=0100`, `m_vi=00A50000`. A byte load of 0x00006 gives `rd=000000A5`.
- Split word store `ba=0x00003`, `wd=11223344`:
  - beat 1: `m_a=0`, `m_bmsk=1000`, `m_vi=44000000`
  - beat 2: `m_a=1`, `m_bmsk=0111`, `m_vi=00112233`
  - `rdy` is low one cycle.
  - The word load from 0x00003 returns 11223344 with `rvld` at E3.
- Wrap: half store `ba=0x1FFFF`, `wd=BEEF`:
  - beat 1: `m_a=7FFF`, `m_bmsk=1000`
  - beat 2: `m_a=0000`, `m_bmsk=0001`
  - The half load from 0x1FFFF returns 0000BEEF.
- `req` held for word loads at 0x0, 0x4, 0x8, 0xC -> `rdy` stays 1, and four consecutive `rvld` pulses return the data in order.
- Assert `rst_n=0` during BEAT2 of a split load -> no beat 2 is issued, `rvld` never asserts, `m_we=0`, and `rdy=1` after release.
